// File: rtl/r5p_csr_arb.sv
// r5p_csr_arb: round-robin arbiter between core and debug requesters for
// read-modify-write CSR accesses (IDLE -> READ -> WRITE).
module r5p_csr_arb #(
   parameter int XW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic [1:0]    c_op,
   input  logic [11:0]   c_adr,
   input  logic [XW-1:0] c_wdt,
   output logic          c_gnt,
   output logic          c_rvld,
   output logic [XW-1:0] c_rdt,
   output logic          c_err,
   input  logic          d_req,
   input  logic [1:0]    d_op,
   input  logic [11:0]   d_adr,
   input  logic [XW-1:0] d_wdt,
   output logic          d_gnt,
   output logic          d_rvld,
   output logic [XW-1:0] d_rdt,
   output logic          d_err,
   output logic [11:0]   csr_adr,
   output logic          csr_we,
   output logic [XW-1:0] csr_wdt,
   input  logic [XW-1:0] csr_rdt,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
   localparam logic [1:0] OP_RD = 2'b00, OP_RW = 2'b01, OP_SET = 2'b10, OP_CLR = 2'b11;

   state_t        r_state, w_next;
   logic          r_last, r_src;
   logic [1:0]    r_op;
   logic [11:0]   r_adr;
   logic [XW-1:0] r_wdt, r_old, w_new;
   logic [XW-1:0] r_c_rdt, r_d_rdt;
   logic          r_c_err, r_d_err;
   logic          w_cg, w_dg, w_wr, w_ro, w_err, w_legal;

   // r_last=1 means debug was granted most recently, so core wins next tie
   always_comb begin
      w_cg    = (r_state == IDLE) && c_req && (!d_req || r_last);
      w_dg    = (r_state == IDLE) && d_req && (!c_req || !r_last);
      w_next  = r_state == IDLE ? ((w_cg || w_dg) ? READ : IDLE) :
                r_state == READ ? WRITE : IDLE;
      w_ro    = &r_adr[11:10];
      w_wr    = (r_op == OP_RW) || (r_op[1] && |r_wdt);
      w_err   = w_ro && w_wr;
      w_legal = !w_ro && w_wr;
      w_new   = r_op == OP_RW  ? r_wdt :
                r_op == OP_SET ? r_old | r_wdt :
                r_op == OP_CLR ? r_old & ~r_wdt : r_old;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_src   <= 1'b0;
         r_op    <= OP_RD;
         r_adr   <= '0;
         r_wdt   <= '0;
         r_old   <= '0;
         r_c_rdt <= '0;
         r_d_rdt <= '0;
         r_c_err <= 1'b0;
         r_d_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_cg || w_dg) begin
            r_src  <= w_dg;
            r_last <= w_dg;
            r_op   <= w_dg ? d_op  : c_op;
            r_adr  <= w_dg ? d_adr : c_adr;
            r_wdt  <= w_dg ? d_wdt : c_wdt;
         end
         // response registers load at READ end so they are valid throughout WRITE
         if (r_state == READ) begin
            r_old <= csr_rdt;
            if (r_src) begin
               r_d_rdt <= csr_rdt;
               r_d_err <= w_err;
            end else begin
               r_c_rdt <= csr_rdt;
               r_c_err <= w_err;
            end
         end
      end
   end

   assign c_gnt   = w_cg;
   assign d_gnt   = w_dg;
   assign c_rvld  = (r_state == WRITE) && !r_src;
   assign d_rvld  = (r_state == WRITE) && r_src;
   assign c_rdt   = r_c_rdt;
   assign d_rdt   = r_d_rdt;
   assign c_err   = r_c_err;
   assign d_err   = r_d_err;
   assign csr_adr = (r_state == IDLE) ? 12'h000 : r_adr;
   assign csr_we  = (r_state == WRITE) && w_legal;
   assign csr_wdt = (r_state == WRITE) ? w_new : '0;
   assign busy    = (r_state != IDLE);
endmodule

// File: tb/tb_r5p_csr_arb.sv
// tb_r5p_csr_arb: directed checks of arbitration, RMW ops, errors and reset abort.
module tb_r5p_csr_arb;
   logic        clk = 1'b0, rst = 1'b1;
   logic        c_req = 0, d_req = 0;
   logic [1:0]  c_op = 0, d_op = 0;
   logic [11:0] c_adr = 0, d_adr = 0;
   logic [31:0] c_wdt = 0, d_wdt = 0;
   logic        c_gnt, c_rvld, c_err, d_gnt, d_rvld, d_err, csr_we, busy;
   logic [31:0] c_rdt, d_rdt, csr_wdt, csr_rdt;
   logic [11:0] csr_adr;
   logic [31:0] mem [0:4095];
   int          n_chk = 0, n_err = 0;

   r5p_csr_arb #(.XW(32)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_op(c_op), .c_adr(c_adr), .c_wdt(c_wdt),
      .c_gnt(c_gnt), .c_rvld(c_rvld), .c_rdt(c_rdt), .c_err(c_err),
      .d_req(d_req), .d_op(d_op), .d_adr(d_adr), .d_wdt(d_wdt),
      .d_gnt(d_gnt), .d_rvld(d_rvld), .d_rdt(d_rdt), .d_err(d_err),
      .csr_adr(csr_adr), .csr_we(csr_we), .csr_wdt(csr_wdt), .csr_rdt(csr_rdt),
      .busy(busy)
   );

   always #5 clk = ~clk;
   assign csr_rdt = mem[csr_adr];
   always @(posedge clk) if (csr_we) mem[csr_adr] <= csr_wdt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // one isolated access: grant at N, READ at N+1, WRITE/response at N+2, IDLE at N+3
   task automatic access(input bit dbg, input logic [1:0] op, input logic [11:0] adr,
                         input logic [31:0] wdt, input logic [31:0] e_rdt,
                         input bit e_we, input logic [31:0] e_wdt, input bit e_err);
      @(negedge clk);
      if (dbg) begin d_req = 1; d_op = op; d_adr = adr; d_wdt = wdt; end
      else begin c_req = 1; c_op = op; c_adr = adr; c_wdt = wdt; end
      #1;
      chk("gnt_own", dbg ? d_gnt : c_gnt, 1);
      chk("gnt_other", dbg ? c_gnt : d_gnt, 0);
      @(posedge clk); #1;
      c_req = 0; d_req = 0;
      @(negedge clk);
      chk("read_busy", busy, 1);
      chk("read_adr", csr_adr, adr);
      chk("read_we", csr_we, 0);
      @(negedge clk);
      chk("wr_we", csr_we, e_we);
      if (e_we) chk("wr_wdt", csr_wdt, e_wdt);
      chk("rvld_own", dbg ? d_rvld : c_rvld, 1);
      chk("rvld_other", dbg ? c_rvld : d_rvld, 0);
      chk("rdt", dbg ? d_rdt : c_rdt, e_rdt);
      chk("err", dbg ? d_err : c_err, e_err);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_rvld", dbg ? d_rvld : c_rvld, 0);
      chk("rdt_hold", dbg ? d_rdt : c_rdt, e_rdt);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_we", csr_we, 0);
      chk("rst_adr", csr_adr, 0);
      chk("rst_wdt", csr_wdt, 0);
      chk("rst_rvld", {c_rvld, d_rvld}, 0);
      chk("rst_rdt", c_rdt | d_rdt, 0);
      chk("rst_err", {c_err, d_err}, 0);
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[12'h340] = 32'h12345678;
      mem[12'h300] = 32'h0000000F;
      mem[12'hC00] = 32'hAAAA5555;
      mem[12'hF14] = 32'h00000007;
      mem[12'h341] = 32'h00000011;
      do_reset();
      chk("rst_gnt", {c_gnt, d_gnt}, 0);
      // core RW
      access(0, 2'b01, 12'h340, 32'hDEADBEEF, 32'h12345678, 1, 32'hDEADBEEF, 0);
      chk("mem_340", mem[12'h340], 32'hDEADBEEF);
      // debug SET then CLR
      access(1, 2'b10, 12'h300, 32'h000000F0, 32'h0000000F, 1, 32'h000000FF, 0);
      access(1, 2'b11, 12'h300, 32'h0000000C, 32'h000000FF, 1, 32'h000000F3, 0);
      chk("mem_300", mem[12'h300], 32'h000000F3);
      // read-only space and zero-mask cases
      access(0, 2'b01, 12'hC00, 32'h00000001, 32'hAAAA5555, 0, 32'h0, 1);
      access(0, 2'b10, 12'hC00, 32'h00000000, 32'hAAAA5555, 0, 32'h0, 0);
      access(0, 2'b11, 12'hC00, 32'h00000100, 32'hAAAA5555, 0, 32'h0, 1);
      access(0, 2'b00, 12'hF14, 32'hFFFFFFFF, 32'h00000007, 0, 32'h0, 0);
      access(1, 2'b10, 12'h300, 32'h00000000, 32'h000000F3, 0, 32'h0, 0);
      chk("mem_C00", mem[12'hC00], 32'hAAAA5555);
      // round-robin with both requests held after a fresh reset
      do_reset();
      @(negedge clk);
      c_req = 1; c_op = 2'b00; c_adr = 12'h300;
      d_req = 1; d_op = 2'b00; d_adr = 12'h340;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk("rr_cgnt", c_gnt, (k % 3 == 0) && ((k / 3) % 2 == 0));
         chk("rr_dgnt", d_gnt, (k % 3 == 0) && ((k / 3) % 2 == 1));
         chk("rr_crvld", c_rvld, (k % 3 == 2) && ((k / 3) % 2 == 0));
         chk("rr_drvld", d_rvld, (k % 3 == 2) && ((k / 3) % 2 == 1));
         @(negedge clk);
      end
      c_req = 0; d_req = 0;
      // reset during READ aborts core RW
      @(negedge clk);
      c_req = 1; c_op = 2'b01; c_adr = 12'h341; c_wdt = 32'h0000BEEF;
      #1 chk("ab_gnt", c_gnt, 1);
      @(posedge clk); #1 c_req = 0;
      @(negedge clk);
      chk("ab_read", busy, 1);
      rst = 1;
      #1;
      chk("ab_we", csr_we, 0);
      @(negedge clk);
      chk("ab_busy", busy, 0);
      chk("ab_rvld", c_rvld, 0);
      rst = 0;
      @(negedge clk);
      chk("ab_we2", csr_we, 0);
      chk("ab_rvld2", c_rvld, 0);
      chk("ab_mem", mem[12'h341], 32'h00000011);
      // debug request arrives during core access
      @(negedge clk);
      c_req = 1; c_op = 2'b01; c_adr = 12'h341; c_wdt = 32'h00000055;
      #1 chk("ov_cgnt", c_gnt, 1);
      @(posedge clk); #1;
      c_req = 0;
      d_req = 1; d_op = 2'b00; d_adr = 12'h341; d_wdt = 32'h0;
      @(negedge clk);
      chk("ov_dwait1", d_gnt, 0);
      @(negedge clk);
      chk("ov_dwait2", d_gnt, 0);
      chk("ov_crvld", c_rvld, 1);
      chk("ov_crdt", c_rdt, 32'h00000011);
      @(negedge clk);
      chk("ov_dgnt", d_gnt, 1);
      @(posedge clk); #1 d_req = 0;
      @(negedge clk);
      chk("ov_dread", d_rvld, 0);
      @(negedge clk);
      chk("ov_drvld", d_rvld, 1);
      chk("ov_drdt", d_rdt, 32'h00000055);
      chk("ov_derr", d_err, 0);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
